// File: rtl/wrr_arb_pkg.sv
// rtl/wrr_arb_pkg.sv - shared types and helpers for the weighted round-robin arbiter
// Contents:
//   state_e  : arbiter FSM state (IDLE, GRANT)
//   wrap_inc : modular increment of a requester index
package wrr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns (idx + 1) mod n for 0 <= idx < n; works for non-power-of-two n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder
// Ports:
//   cand   in  [N]     candidate vector
//   start  in  [IDX_W] index searched first; search wraps modulo N
//   onehot out [N]     one-hot of the first set candidate at or after start
//   idx    out [IDX_W] index of that candidate
//   any    out         at least one candidate is set
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(start) + i) % N;
      if (!any && cand[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// rtl/weighted_rr_arbiter.sv - weighted round-robin arbiter with burst credits
// Ports:
//   clk       in          rising-edge clock
//   rst_n     in          asynchronous active-low reset
//   lock      in          hold current owner past credit expiry (only with WRR_ARB_LOCK_EN)
//   req       in  [N]     request vector, held high while wanted or in use
//   weight    in  [N*WEIGHT_W] per-requester burst credit, requester i at [i*WEIGHT_W +: WEIGHT_W]
//   gnt       out [N]     registered one-hot grant, zero when idle
//   gnt_id    out [IDX_W] index of current owner, meaningful while gnt_valid
//   gnt_valid out         any grant active
// Optional feature macro: WRR_ARB_LOCK_EN
module weighted_rr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef WRR_ARB_LOCK_EN
  input  logic                  lock,
`endif
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  output logic [N-1:0]          gnt,
  output logic [IDX_W-1:0]      gnt_id,
  output logic                  gnt_valid
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gnt_id_q, gnt_id_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [N-1:0]          gnt_q, gnt_d;
  logic                  gnt_valid_q, gnt_valid_d;

  logic [IDX_W-1:0]      next_idx;
  logic [IDX_W-1:0]      pick_start;
  logic [N-1:0]          pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [WEIGHT_W-1:0]   win_weight;
  logic [WEIGHT_W-1:0]   load_credit;
  logic                  owner_req;
  logic                  lock_hold;
  logic                  rel;

`ifdef WRR_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  assign next_idx   = IDX_W'(wrap_inc(32'(gnt_id_q), 32'(N)));
  // From IDLE search starts at ptr; on handover it starts just past the owner.
  // req is used unmasked: a dropped owner bit is already clear, and a still-set
  // owner bit lets a sole requester be re-granted when the search wraps to it.
  assign pick_start = (state_q == GRANT) ? next_idx : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .cand   (req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign win_weight  = weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign load_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
  assign owner_req   = |(req & gnt_q);
  assign rel         = !owner_req || ((credit_q == WEIGHT_W'(1)) && !lock_hold);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    credit_d    = credit_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_d       = pick_onehot;
          gnt_id_d    = pick_idx;
          credit_d    = load_credit;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = next_idx;
          if (pick_any) begin
            gnt_d    = pick_onehot;
            gnt_id_d = pick_idx;
            credit_d = load_credit;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
          end
        end else if (!lock_hold) begin
          // No release implies credit > 1 here, so this never reaches 0.
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      credit_q    <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      credit_q    <= credit_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb/tb_weighted_rr_arbiter.sv - directed self-checking bench for weighted_rr_arbiter
module tb_weighted_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_valid;
`ifdef WRR_ARB_LOCK_EN
  logic        lock;
`endif

  int total;
  int passed;

  weighted_rr_arbiter #(.N(4), .WEIGHT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef WRR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .weight    (weight),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compares {gnt_valid, gnt_id, gnt} against an active grant to requester k.
  task automatic expect_owner(input string tag, input int k);
    logic [6:0] exp;
    exp = {1'b1, 2'(k), 4'(1 << k)};
    chk(tag, 32'({gnt_valid, gnt_id, gnt}), 32'(exp));
  endtask

  task automatic expect_idle(input string tag);
    chk(tag, 32'({gnt_valid, gnt}), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int rot_seq [13] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1, 1};

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    req    = 4'b1111;
    weight = 16'h4321;
`ifdef WRR_ARB_LOCK_EN
    lock   = 1'b0;
`endif

    // Reset holds outputs low even with all requests present.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'(0));
    chk("reset_valid", 32'(gnt_valid), 32'(0));
    chk("reset_id", 32'(gnt_id), 32'(0));

    // Weighted rotation with weights {1,2,3,4}, first grant from ptr = 0.
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      expect_owner($sformatf("rotate_%0d", i), rot_seq[i]);
    end

    // Early release by owner 1 after 2 beats; mid-burst weight change ignored.
    do_reset();
    weight = 16'h0040;
    req    = 4'b0010;
    step(); expect_owner("early_load1", 1);
    req    = 4'b1111;
    weight = 16'h1111;
    step(); expect_owner("early_beat2", 1);
    step(); expect_owner("early_hold1", 1);
    req    = 4'b1101;
    step(); expect_owner("early_to2", 2);
    req    = 4'b1111;
    step(); expect_owner("early_to3", 3);
    step(); expect_owner("early_to0", 0);
    step(); expect_owner("early_to1", 1);

    // Sole requester: continuous grant across credit reloads, weight 2 then 0.
    do_reset();
    weight = 16'h0200;
    req    = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      step();
      expect_owner($sformatf("sole_w2_%0d", i), 2);
    end
    weight = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_owner($sformatf("sole_w0_%0d", i), 2);
    end

    // Asynchronous reset in the middle of owner 3's burst.
    do_reset();
    weight = 16'h4000;
    req    = 4'b1000;
    step(); expect_owner("async_pre0", 3);
    step(); expect_owner("async_pre1", 3);
    #3;
    rst_n = 1'b0;
    #1;
    expect_idle("async_drop");
    chk("async_id", 32'(gnt_id), 32'(0));
    step();
    expect_idle("async_held");
    rst_n = 1'b1;
    req   = 4'b1000;
    step(); expect_owner("async_regrant", 3);
    req   = 4'b0000;
    step(); expect_idle("release_to_idle");
    req   = 4'b0100;
    step(); expect_owner("idle_latency", 2);

`ifdef WRR_ARB_LOCK_EN
    // Lock suppresses credit expiry of owner 0 (weight 1) for 5 cycles.
    do_reset();
    weight = 16'h0011;
    req    = 4'b0011;
    lock   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_owner($sformatf("lock_hold_%0d", i), 0);
    end
    lock = 1'b0;
    step(); expect_owner("lock_handover", 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Parametrised weighted round-robin arbiter: N requesters share one resource; each grant is held for up to a per-requester credit of beats, then priority rotates to the next index after the owner. It is the successor to the single-cycle rotating arbiter, adding:
- registered one-hot grant with an encoded id;
- burst credits (weights);
- back-to-back re-arbitration with no idle bubble.

It sits in front of any shared bus or port that needs fair but weighted access.

## Interface
- N, default 4: number of requesters, N >= 2.
- WEIGHT_W, default 4: width of each requester's weight field.
- IDX_W, default $clog2(N): width of the grant id. Local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; a requester holds its bit high while it wants or uses the resource.
- weight  input  N*WEIGHT_W  flat weights; requester i uses bits [i*WEIGHT_W +: WEIGHT_W].
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_id  output  IDX_W  index of the current owner; valid only while gnt_valid = 1.
- gnt_valid  output  1  high when any gnt bit is high.
- lock  input  1  present only with WRR_ARB_LOCK_EN.

## Operation
Reset values:
- gnt = 0, gnt_id = 0, gnt_valid = 0.
- Priority pointer ptr = 0.
- Credit counter = 0.
- FSM state = IDLE.

Pick function: selects the first set bit of a candidate vector, searching from ptr upward and wrapping modulo N.

IDLE state:
- If req != 0, the winner w = pick(req, ptr).
- At the next edge: gnt = onehot(w), gnt_id = w, credit = max(weight[w], 1). Go to GRANT.
- If req = 0, stay in IDLE.

GRANT state, owner k, remaining credit c; decisions use req sampled in the current cycle:
- **Release condition:** req[k] = 0 or c = 1.
- **On release:**
  - ptr <= (k+1) mod N.
  - Candidates = req with bit k cleared if req[k] = 0.
  - If candidates != 0: grant w = pick(candidates, (k+1) mod N) at the next edge, reload credit from weight[w], stay in GRANT.
  - Otherwise: gnt = 0, go to IDLE.
- **No release:** keep owner, c <= c - 1.

Rules:
- Each cycle with gnt[k] = 1 and req[k] = 1 is one consumed beat.
- A cycle with gnt[k] = 1 and req[k] = 0 is a release cycle, not a beat.
- Weight 0 is treated as 1.
- Weight is sampled only when a grant is loaded. Changes mid-burst have no effect until the next grant.
- Sole requester with credit expired: re-granted immediately with fresh credit (pick wraps back to k); gnt stays high continuously.
- Simultaneous release and new requests: resolved in the same edge, no bubble.
- Credit counter is WEIGHT_W bits wide and never underflows below 1 while granted.
- At most one gnt bit is ever high.

## Timing
- Request-to-grant latency: 1 cycle from IDLE (req sampled at edge t, gnt high after edge t).
- Owner handover: 0 idle cycles. The new gnt is registered on the edge that ends the old owner's last beat.
- Maximum continuous hold by requester i while others request: max(weight[i], 1) beats.
- Starvation bound for any requester: sum over the others of max(weight, 1) beats, plus 1 cycle.
- Reset mid-burst: all outputs drop to their reset values asynchronously on rst_n falling. The first grant after rst_n rises restarts from ptr = 0.

## Configuration
Macro: WRR_ARB_LOCK_EN.
- **Defined:**
  - Adds input lock.
  - While gnt_valid = 1 and lock = 1, credit expiry is suppressed (c holds at its current value, minimum 1), so the owner keeps the grant until req[k] drops.
  - On lock deassertion the remaining credit resumes counting.
  - lock is ignored in IDLE.
- **Undefined:** no lock port. Credit expiry always applies.

## Structure
- Package wrr_arb_pkg:
  - state enum {IDLE, GRANT};
  - helper function for the modular increment of an index.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: candidate vector [N], start pointer [IDX_W].
  - Outputs: one-hot [N], index [IDX_W], any.
  - Instanced once in weighted_rr_arbiter.
- Top module holds the FSM, ptr, credit counter and output registers.

## Test plan
- Reset: rst_n = 0 with req = 4'b1111 → gnt = 0, gnt_valid = 0. After release, the first grant is gnt = 4'b0001, gnt_id = 0.
- Weighted rotation: N = 4, weights {1,2,3,4}, req = 4'b1111 held → grant sequence 0×1, 1×2, 2×3, 3×4, 0×1… with gnt_valid continuously high.
- Early release: owner 1 with weight 4 drops req after 2 beats → next edge grants 2. ptr becomes 2. Requester 1 is not re-granted ahead of 2, 3, 0.
- Sole requester: req = 4'b0100, weight[2] = 2 → gnt = 4'b0100 continuously, no gap at credit reload. With weight[2] = 0 the behaviour is the same (credit 1 per grant).
- Asynchronous reset mid-burst: assert rst_n = 0 mid-cycle during owner 3's burst → gnt clears without a clock edge. After release with req = 4'b1000, gnt = 4'b1000 after 1 cycle.
- With WRR_ARB_LOCK_EN: owner 0 with weight 1, lock = 1 for 5 cycles, req = 4'b0011 → gnt = 4'b0001 for all 5 cycles. The cycle after lock drops, the grant passes to 1.
